// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin whole-packet arbiter (UDP header beat + 8-bit AXI-Stream payload).
// Optional payload stall timeout: define UDP_TX_ARBITER_TIMEOUT_EN.
`default_nettype none

module udp_tx_arbiter #(
    parameter int N       = 4,
    parameter int HDR_W   = 336,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           s_hdr_valid,
    output logic [N-1:0]           s_hdr_ready,
    input  logic [N*HDR_W-1:0]     s_hdr_data,
    input  logic [N*8-1:0]         s_tdata,
    input  logic [N-1:0]           s_tvalid,
    output logic [N-1:0]           s_tready,
    input  logic [N-1:0]           s_tlast,
    input  logic [N-1:0]           s_tuser,
    output logic                   m_hdr_valid,
    input  logic                   m_hdr_ready,
    output logic [HDR_W-1:0]       m_hdr_data,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   m_tuser,
    output logic [$clog2(N)-1:0]   grant_idx,
    output logic                   busy
);

    localparam int IW = $clog2(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
`ifdef UDP_TX_ARBITER_TIMEOUT_EN
    localparam logic [1:0] S_DRAIN   = 2'd3;
`endif

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    next_ptr;
    logic [IW-1:0]    sel;
    logic             found;
    logic [N-1:0]     rot_req;
    logic [IW-1:0]    rot_off;
    logic [IW:0]      sel_sum;
    logic [HDR_W-1:0] sel_hdr;
    logic [7:0]       lane_data;
    logic             lane_valid;
    logic             lane_last;
    logic             lane_user;
    logic             synth;
    logic             pkt_done;

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    assign rot_req = N'({s_hdr_valid, s_hdr_valid} >> ptr);

    always_comb begin
        found   = 1'b0;
        rot_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                found   = 1'b1;
                rot_off = IW'(i);
            end
        end
        sel_sum = {1'b0, ptr} + {1'b0, rot_off};
        if (sel_sum >= (IW+1)'(N)) begin
            sel_sum = sel_sum - (IW+1)'(N);
        end
        sel = sel_sum[IW-1:0];
    end

    always_comb begin
        sel_hdr = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sel_hdr = s_hdr_data[i*HDR_W +: HDR_W];
            end
        end
    end

    always_comb begin
        lane_data  = '0;
        lane_valid = 1'b0;
        lane_last  = 1'b0;
        lane_user  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IW'(i)) begin
                lane_data  = s_tdata[i*8 +: 8];
                lane_valid = s_tvalid[i];
                lane_last  = s_tlast[i];
                lane_user  = s_tuser[i];
            end
        end
    end

    assign next_ptr = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);

`ifdef UDP_TX_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_cnt;

    assign synth = (state == S_PAYLOAD) && (stall_cnt == CW'(TIMEOUT));

    // Frozen while the synthetic beat waits so a late source beat cannot cancel it.
    always_ff @(posedge clk) begin
        if (!rst_n || state != S_PAYLOAD) begin
            stall_cnt <= '0;
        end else if (synth) begin
            stall_cnt <= stall_cnt;
        end else if (lane_valid) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    assign pkt_done = ((state == S_PAYLOAD) && !synth && lane_valid && lane_last && m_tready) ||
                      ((state == S_DRAIN) && lane_valid && lane_last);
`else
    assign synth    = 1'b0;
    assign pkt_done = (state == S_PAYLOAD) && lane_valid && lane_last && m_tready;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            grant_idx  <= '0;
            m_hdr_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && found) begin
                grant_idx  <= sel;
                m_hdr_data <= sel_hdr;
            end
            if (pkt_done) begin
                ptr <= next_ptr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (m_hdr_ready) begin
                    state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
`ifdef UDP_TX_ARBITER_TIMEOUT_EN
                if (synth && m_tready) begin
                    state_nxt = S_DRAIN;
                end else
`endif
                if (pkt_done) begin
                    state_nxt = S_IDLE;
                end
            end
`ifdef UDP_TX_ARBITER_TIMEOUT_EN
            S_DRAIN: begin
                if (pkt_done) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_hdr_ready = '0;
        s_tready    = '0;
        m_hdr_valid = 1'b0;
        m_tdata     = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tuser     = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_HDR: begin
                m_hdr_valid            = 1'b1;
                s_hdr_ready[grant_idx] = m_hdr_ready;
            end
            S_PAYLOAD: begin
                if (synth) begin
                    m_tvalid = 1'b1;
                    m_tlast  = 1'b1;
                    m_tuser  = 1'b1;
                end else begin
                    m_tdata             = lane_data;
                    m_tvalid            = lane_valid;
                    m_tlast             = lane_last;
                    m_tuser             = lane_user;
                    s_tready[grant_idx] = m_tready;
                end
            end
`ifdef UDP_TX_ARBITER_TIMEOUT_EN
            S_DRAIN: begin
                s_tready[grant_idx] = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: vector table plus round-robin, reset and timeout sequences.
`default_nettype none

module tb_udp_tx_arbiter;

    localparam int N     = 4;
    localparam int HDR_W = 336;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      s_hdr_valid;
    logic [N-1:0]      s_hdr_ready;
    logic [N*HDR_W-1:0] s_hdr_data;
    logic [N*8-1:0]    s_tdata;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tuser;
    logic              m_hdr_valid;
    logic              m_hdr_ready;
    logic [HDR_W-1:0]  m_hdr_data;
    logic [7:0]        m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;
    logic [1:0]        grant_idx;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    udp_tx_arbiter #(.N(N), .HDR_W(HDR_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr_data(s_hdr_data),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr_data(m_hdr_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .grant_idx(grant_idx), .busy(busy)
    );

    typedef struct {
        logic [3:0] hv, tv, tl, tu;
        logic [7:0] d;
        logic       mhr, mtr;
        logic       e_hv, e_tv, e_tl, e_tu;
        logic [7:0] e_td;
        logic [3:0] e_hr, e_tr;
        logic [1:0] e_g;
        logic       e_busy;
        int         e_hdr;
    } vec_t;

    vec_t vecs[24];

    function automatic logic [HDR_W-1:0] hdr_of(input int lane);
        logic [7:0] b;
        b = 8'hA3 + 8'(lane);
        return {42{b}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_hdr(input string nm, input int lane);
        checks++;
        if (m_hdr_data !== hdr_of(lane)) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, m_hdr_data, hdr_of(lane));
        end
    endtask

    // Lane i carries byte d + 16*i so routing errors show up in m_tdata.
    task automatic set_in(input logic [3:0] hv, input logic [3:0] tv, input logic [3:0] tl,
                          input logic [3:0] tu, input logic [7:0] d, input logic mhr, input logic mtr);
        @(negedge clk);
        s_hdr_valid = hv;
        s_tvalid    = tv;
        s_tlast     = tl;
        s_tuser     = tu;
        for (int i = 0; i < N; i++) s_tdata[i*8 +: 8] = d + 8'(16 * i);
        m_hdr_ready = mhr;
        m_tready    = mtr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_hdr_valid = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
        m_hdr_ready = 1'b1; m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) s_hdr_data[i*HDR_W +: HDR_W] = hdr_of(i);
        //            hv       tv       tl       tu       d      mhr   mtr  | hv   tv   tl   tu   td     hr       tr       g     busy  hdr
        vecs[0]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, -1};
        vecs[1]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b0000, 2'd2, 1'b1, 2};
        vecs[2]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h21, 4'b0000, 4'b0100, 2'd2, 1'b1, -1};
        vecs[3]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 4'b0000, 4'b0100, 2'd2, 1'b1, -1};
        vecs[4]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h23, 4'b0000, 4'b0100, 2'd2, 1'b1, -1};
        vecs[5]  = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h24, 4'b0000, 4'b0100, 2'd2, 1'b1, -1};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd2, 1'b0, -1};
        vecs[7]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd2, 1'b0, -1};
        for (int k = 8; k < 13; k++)
            vecs[k] = '{4'b1101, 4'b1000, 4'b0000, 4'b0000, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd3, 1'b1, 3};
        vecs[13] = '{4'b1101, 4'b1000, 4'b0000, 4'b0000, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1000, 4'b0000, 2'd3, 1'b1, 3};
        vecs[14] = '{4'b0101, 4'b1000, 4'b0000, 4'b0000, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h35, 4'b0000, 4'b1000, 2'd3, 1'b1, -1};
        vecs[15] = '{4'b0101, 4'b1000, 4'b0000, 4'b0000, 8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h36, 4'b0000, 4'b0000, 2'd3, 1'b1, -1};
        vecs[16] = '{4'b0101, 4'b1000, 4'b0000, 4'b0000, 8'h06, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h36, 4'b0000, 4'b1000, 2'd3, 1'b1, -1};
        vecs[17] = '{4'b0101, 4'b1000, 4'b1000, 4'b0000, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h37, 4'b0000, 4'b0000, 2'd3, 1'b1, -1};
        vecs[18] = '{4'b0101, 4'b1000, 4'b1000, 4'b0000, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h37, 4'b0000, 4'b1000, 2'd3, 1'b1, -1};
        vecs[19] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd3, 1'b0, -1};
        vecs[20] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0001, 4'b0000, 2'd0, 1'b1, 0};
        vecs[21] = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 4'b0000, 4'b0001, 2'd0, 1'b1, -1};
        vecs[22] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, -1};
        vecs[23] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, -1};

        rst_n = 1'b0;
        do_reset();

        for (int k = 0; k < 24; k++) begin
            set_in(vecs[k].hv, vecs[k].tv, vecs[k].tl, vecs[k].tu, vecs[k].d, vecs[k].mhr, vecs[k].mtr);
            #1;
            chk($sformatf("v%0d hdr_valid", k), 64'(m_hdr_valid), 64'(vecs[k].e_hv));
            chk($sformatf("v%0d tvalid", k), 64'(m_tvalid), 64'(vecs[k].e_tv));
            chk($sformatf("v%0d tlast", k), 64'(m_tlast), 64'(vecs[k].e_tl));
            chk($sformatf("v%0d tuser", k), 64'(m_tuser), 64'(vecs[k].e_tu));
            chk($sformatf("v%0d s_hdr_ready", k), 64'(s_hdr_ready), 64'(vecs[k].e_hr));
            chk($sformatf("v%0d s_tready", k), 64'(s_tready), 64'(vecs[k].e_tr));
            chk($sformatf("v%0d grant_idx", k), 64'(grant_idx), 64'(vecs[k].e_g));
            chk($sformatf("v%0d busy", k), 64'(busy), 64'(vecs[k].e_busy));
            if (vecs[k].e_tv) chk($sformatf("v%0d tdata", k), 64'(m_tdata), 64'(vecs[k].e_td));
            if (vecs[k].e_hdr >= 0) chk_hdr($sformatf("v%0d hdr_data", k), vecs[k].e_hdr);
        end

        // Round-robin: all lanes request, 3-byte payloads, lane 0 sends twice.
        begin
            int pk[4];
            bit hd[4];
            int bt[4];
            int order[$];
            int exp_order[5];
            bit prev_last;
            int cyc;
            pk = '{2, 1, 1, 1};
            hd = '{0, 0, 0, 0};
            bt = '{0, 0, 0, 0};
            exp_order = '{0, 1, 2, 3, 0};
            prev_last = 1'b0;
            cyc = 0;
            do_reset();
            while ((pk[0] + pk[1] + pk[2] + pk[3]) > 0 && cyc < 200) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    s_hdr_valid[i]     = (pk[i] > 0) && !hd[i];
                    s_tvalid[i]        = (pk[i] > 0);
                    s_tlast[i]         = (bt[i] == 2);
                    s_tuser[i]         = 1'b0;
                    s_tdata[i*8 +: 8]  = 8'(16 * i + bt[i] + 1);
                end
                m_hdr_ready = 1'b1;
                m_tready    = 1'b1;
                #1;
                if (prev_last) chk("rr idle gap busy", 64'(busy), 64'd0);
                for (int i = 0; i < N; i++)
                    if (!hd[i]) chk($sformatf("rr early tready lane%0d", i), 64'(s_tready[i]), 64'd0);
                if (m_tvalid) begin
                    chk("rr tdata", 64'(m_tdata), 64'(16 * int'(grant_idx) + bt[grant_idx] + 1));
                    chk("rr tlast", 64'(m_tlast), 64'(bt[grant_idx] == 2));
                    if (m_tlast) order.push_back(int'(grant_idx));
                end
                prev_last = m_tvalid && m_tready && m_tlast;
                for (int i = 0; i < N; i++) begin
                    if (s_hdr_valid[i] && s_hdr_ready[i]) hd[i] = 1'b1;
                    if (s_tvalid[i] && s_tready[i]) begin
                        if (bt[i] == 2) begin
                            bt[i] = 0;
                            hd[i] = 1'b0;
                            pk[i]--;
                        end else begin
                            bt[i]++;
                        end
                    end
                end
                cyc++;
            end
            chk("rr packets finished", 64'(pk[0] + pk[1] + pk[2] + pk[3]), 64'd0);
            chk("rr packet count", 64'(order.size()), 64'd5);
            for (int i = 0; i < 5; i++)
                if (i < order.size()) chk($sformatf("rr order[%0d]", i), 64'(order[i]), 64'(exp_order[i]));
        end

        // Pointer now 1: lane 1 granted, reset mid-payload, then lane 0 wins a 0/1 contest.
        set_in(4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
        set_in(4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
        #1 chk("rst seq grant before", 64'(grant_idx), 64'd1);
        set_in(4'b0000, 4'b0010, 4'b0000, 4'b0000, 8'h01, 1'b1, 1'b1);
        #1 chk("rst seq tdata", 64'(m_tdata), 64'h11);
        set_in(4'b0000, 4'b0010, 4'b0000, 4'b0000, 8'h02, 1'b1, 1'b1);
        rst_n = 1'b0;
        set_in(4'b0000, 4'b0010, 4'b0010, 4'b0000, 8'h03, 1'b1, 1'b1);
        #1;
        chk("rst seq tvalid", 64'(m_tvalid), 64'd0);
        chk("rst seq tlast", 64'(m_tlast), 64'd0);
        chk("rst seq tready", 64'(s_tready), 64'd0);
        chk("rst seq busy", 64'(busy), 64'd0);
        chk("rst seq grant", 64'(grant_idx), 64'd0);
        chk("rst seq hdr_data", 64'(m_hdr_data[63:0]), 64'd0);
        rst_n = 1'b1;
        set_in(4'b0011, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
        set_in(4'b0011, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1);
        #1;
        chk("rst seq regrant", 64'(grant_idx), 64'd0);
        chk("rst seq hdr_valid", 64'(m_hdr_valid), 64'd1);
        chk_hdr("rst seq hdr_data lane0", 0);

`ifdef UDP_TX_ARBITER_TIMEOUT_EN
        do_reset();
        set_in(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
        set_in(4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
        set_in(4'b0000, 4'b0001, 4'b0000, 4'b0000, 8'h01, 1'b1, 1'b1);
        set_in(4'b0000, 4'b0001, 4'b0000, 4'b0000, 8'h02, 1'b1, 1'b1);
        #1 chk("to byte2", 64'(m_tdata), 64'h02);
        for (int k = 0; k < 8; k++) begin
            set_in(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
            #1 chk($sformatf("to stall%0d tvalid", k), 64'(m_tvalid), 64'd0);
        end
        set_in(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h55, 1'b1, 1'b1);
        #1;
        chk("to synth tvalid", 64'(m_tvalid), 64'd1);
        chk("to synth tdata", 64'(m_tdata), 64'd0);
        chk("to synth tlast", 64'(m_tlast), 64'd1);
        chk("to synth tuser", 64'(m_tuser), 64'd1);
        chk("to synth s_tready", 64'(s_tready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            set_in(4'b0011, 4'b0001, (k == 2) ? 4'b0001 : 4'b0000, 4'b0000, 8'(3 + k), 1'b1, 1'b1);
            #1;
            chk($sformatf("to drain%0d tready", k), 64'(s_tready), 64'b0001);
            chk($sformatf("to drain%0d tvalid", k), 64'(m_tvalid), 64'd0);
        end
        set_in(4'b0011, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
        #1 chk("to idle busy", 64'(busy), 64'd0);
        set_in(4'b0011, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
        #1 chk("to next grant", 64'(grant_idx), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
